// File: rtl/ddr4_phy_dly_pkg.sv
// Shared types and constants for the DDR4 PHY delay-line step controllers.
package ddr4_phy_dly_pkg;

  localparam int unsigned TAP_W       = 8;
  localparam int unsigned STEP_W      = 8;
  localparam int unsigned GAP_W       = 4;
  localparam int unsigned TAP_DEFAULT = 1;
  localparam int unsigned TAP_MAX     = 255;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StLoad,
    StGap,
    StDone
  } dly_state_e;

endpackage

// File: rtl/ddr4_ba_dly_step_ctrl_if.sv
// Step-request handshake and status bus between a requester and the step controller.
interface ddr4_ba_dly_step_ctrl_if;
  import ddr4_phy_dly_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_lane;
  logic              req_dir;
  logic              req_load;
  logic [STEP_W-1:0] req_steps;
  logic              done;
  logic              status_oor;
  logic [TAP_W-1:0]  tap_0;
  logic [TAP_W-1:0]  tap_1;

  modport master (
    output req_valid, req_lane, req_dir, req_load, req_steps,
    input  req_ready, done, status_oor, tap_0, tap_1
  );

  modport slave (
    input  req_valid, req_lane, req_dir, req_load, req_steps,
    output req_ready, done, status_oor, tap_0, tap_1
  );

endinterface

// File: rtl/ddr4_dly_tap_cnt.sv
// Per-lane tap tracker: load to default, saturating increment/decrement.
module ddr4_dly_tap_cnt #(
  parameter int unsigned TapDefault = 1,
  parameter int unsigned TapMax     = 255
) (
  input  logic                              clk,
  input  logic                              arst,
  input  logic                              load,
  input  logic                              inc,
  input  logic                              dec,
  output logic [ddr4_phy_dly_pkg::TAP_W-1:0] tap
);
  import ddr4_phy_dly_pkg::*;

  localparam logic [TAP_W-1:0] DefV = TapDefault[TAP_W-1:0];
  localparam logic [TAP_W-1:0] MaxV = TapMax[TAP_W-1:0];

  // Tap count register; load wins over stepping.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      tap <= DefV;
    end else if (load) begin
      tap <= DefV;
    end else if (inc && (tap != MaxV)) begin
      tap <= tap + 1'b1;
    end else if (dec && (tap != '0)) begin
      tap <= tap - 1'b1;
    end
  end

endmodule

// File: rtl/ddr4_ba_dly_step_ctrl.sv
// Steps or reloads the BA0/BA1 IOD delay lines one tap at a time with a settle gap.
module ddr4_ba_dly_step_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned TAP_DEFAULT   = ddr4_phy_dly_pkg::TAP_DEFAULT,
  parameter int unsigned TAP_MAX       = ddr4_phy_dly_pkg::TAP_MAX
) (
  input  logic                          fab_clk,
  input  logic                          arst,
  ddr4_ba_dly_step_ctrl_if.slave        bus,
  output logic                          delay_line_move_0,
  output logic                          delay_line_move_1,
  output logic                          delay_line_direction_0,
  output logic                          delay_line_direction_1,
  output logic                          delay_line_load_0,
  output logic                          delay_line_load_1,
  input  logic                          delay_line_out_of_range_0,
  input  logic                          delay_line_out_of_range_1
);
  import ddr4_phy_dly_pkg::*;

  localparam logic [TAP_W-1:0] TapMaxV  = TAP_MAX[TAP_W-1:0];
  localparam int unsigned      GapInitI = SETTLE_CYCLES - 1;
  localparam logic [GAP_W-1:0] GapInit  = GapInitI[GAP_W-1:0];

  dly_state_e        state_q, state_d;
  logic              lane_q, lane_d, dir_q, dir_d, oor_q, oor_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              init_q;
  logic [1:0]        move_q, load_q, dl_dir_q;
  logic              done_q, status_q;
  logic [TAP_W-1:0]  tap_0, tap_1, cur_tap;
  logic              ready, at_bound, sel_oor;
  logic [1:0]        lane_sel, tap_load, tap_inc, tap_dec;

  // init_q holds ready low until the first clock edge after reset release.
  assign ready    = init_q && (state_q == StIdle);
  assign cur_tap  = lane_q ? tap_1 : tap_0;
  assign at_bound = dir_q ? (cur_tap == TapMaxV) : (cur_tap == '0);
  assign sel_oor  = lane_q ? delay_line_out_of_range_1 : delay_line_out_of_range_0;
  assign lane_sel = lane_q ? 2'b10 : 2'b01;
  assign tap_load = (state_q == StLoad) ? lane_sel : 2'b00;
  assign tap_inc  = ((state_q == StPulse) && dir_q) ? lane_sel : 2'b00;
  assign tap_dec  = ((state_q == StPulse) && !dir_q) ? lane_sel : 2'b00;

  // FSM state register.
  always_ff @(posedge fab_clk or posedge arst) begin
    if (arst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Next state and request bookkeeping.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    dir_d   = dir_q;
    oor_d   = oor_q;
    steps_d = steps_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (ready && bus.req_valid) begin
          lane_d  = bus.req_lane;
          dir_d   = bus.req_dir;
          oor_d   = 1'b0;
          steps_d = bus.req_load ? '0 : bus.req_steps;
          if (bus.req_load)             state_d = StLoad;
          else if (bus.req_steps == '0) state_d = StDone;
          else                          state_d = StSetup;
        end
      end
      StSetup: begin
        if (at_bound) begin
          state_d = StDone;
          oor_d   = 1'b1;
        end else begin
          state_d = StPulse;
        end
      end
      StPulse: begin
        state_d = StGap;
        steps_d = steps_q - 1'b1;
        gap_d   = GapInit;
      end
      StLoad: begin
        state_d = StGap;
        gap_d   = GapInit;
      end
      StGap: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (sel_oor) begin
          state_d = StDone;
          oor_d   = 1'b1;
        end else if (steps_q != '0) begin
          // Boundary check precedes every pulse, not just the first.
          if (at_bound) begin
            state_d = StDone;
            oor_d   = 1'b1;
          end else begin
            state_d = StPulse;
          end
        end else begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request fields and step/gap counters.
  always_ff @(posedge fab_clk or posedge arst) begin
    if (arst) begin
      lane_q  <= 1'b0;
      dir_q   <= 1'b0;
      oor_q   <= 1'b0;
      steps_q <= '0;
      gap_q   <= '0;
    end else begin
      lane_q  <= lane_d;
      dir_q   <= dir_d;
      oor_q   <= oor_d;
      steps_q <= steps_d;
      gap_q   <= gap_d;
    end
  end

  // Registered delay-line controls and completion status.
  always_ff @(posedge fab_clk or posedge arst) begin
    if (arst) begin
      init_q   <= 1'b0;
      move_q   <= 2'b00;
      load_q   <= 2'b00;
      dl_dir_q <= 2'b00;
      done_q   <= 1'b0;
      status_q <= 1'b0;
    end else begin
      init_q   <= 1'b1;
      move_q   <= tap_inc | tap_dec;
      load_q   <= tap_load;
      if (state_q == StSetup) dl_dir_q[lane_q] <= dir_q;
      done_q   <= (state_q == StDone);
      status_q <= (state_q == StDone) && oor_q;
    end
  end

  ddr4_dly_tap_cnt #(
    .TapDefault (TAP_DEFAULT),
    .TapMax     (TAP_MAX)
  ) u_tap_0 (
    .clk  (fab_clk),
    .arst (arst),
    .load (tap_load[0]),
    .inc  (tap_inc[0]),
    .dec  (tap_dec[0]),
    .tap  (tap_0)
  );

  ddr4_dly_tap_cnt #(
    .TapDefault (TAP_DEFAULT),
    .TapMax     (TAP_MAX)
  ) u_tap_1 (
    .clk  (fab_clk),
    .arst (arst),
    .load (tap_load[1]),
    .inc  (tap_inc[1]),
    .dec  (tap_dec[1]),
    .tap  (tap_1)
  );

  assign bus.req_ready           = ready;
  assign bus.done                = done_q;
  assign bus.status_oor          = status_q;
  assign bus.tap_0               = tap_0;
  assign bus.tap_1               = tap_1;
  assign delay_line_move_0       = move_q[0];
  assign delay_line_move_1       = move_q[1];
  assign delay_line_load_0       = load_q[0];
  assign delay_line_load_1       = load_q[1];
  assign delay_line_direction_0  = dl_dir_q[0];
  assign delay_line_direction_1  = dl_dir_q[1];

endmodule

// File: tb/tb_ddr4_ba_dly_step_ctrl.sv
// Bench for ddr4_ba_dly_step_ctrl: timeline model of each request plus directed pins.
module tb_ddr4_ba_dly_step_ctrl;

  localparam int          S     = 3;
  localparam int          TMAX  = 20;
  localparam int          TDEF  = 1;
  localparam int          MAXL  = 128;
  localparam logic [7:0]  TMAX8 = 8'(TMAX);
  localparam logic [7:0]  TDEF8 = 8'(TDEF);

  logic clk  = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  ddr4_ba_dly_step_ctrl_if bus ();
  logic mv0, mv1, dr0, dr1, ld0, ld1, oor0, oor1;

  ddr4_ba_dly_step_ctrl #(
    .SETTLE_CYCLES (S),
    .TAP_DEFAULT   (TDEF),
    .TAP_MAX       (TMAX)
  ) dut (
    .fab_clk                   (clk),
    .arst                      (arst),
    .bus                       (bus),
    .delay_line_move_0         (mv0),
    .delay_line_move_1         (mv1),
    .delay_line_direction_0    (dr0),
    .delay_line_direction_1    (dr1),
    .delay_line_load_0         (ld0),
    .delay_line_load_1         (ld1),
    .delay_line_out_of_range_0 (oor0),
    .delay_line_out_of_range_1 (oor1)
  );

  // {ready, done, status, mv1, mv0, ld1, ld0, dir1, dir0, tap1, tap0}
  logic [24:0] act;
  assign act = {bus.req_ready, bus.done, bus.status_oor, mv1, mv0, ld1, ld0, dr1, dr0,
                bus.tap_1, bus.tap_0};

  int              tests = 0;
  int              fails = 0;
  logic            chk_en = 1'b0;
  logic [24:0]     exp_v;
  logic [24:0]     tl [MAXL];
  logic [1:0][7:0] m_tap;
  logic [1:0]      m_dir;

  function automatic logic [24:0] pack(input logic rdy, input logic dn, input logic st,
                                       input logic m1, input logic m0, input logic l1,
                                       input logic l0, input logic [1:0] d,
                                       input logic [1:0][7:0] t);
    return {rdy, dn, st, m1, m0, l1, l0, d, t};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Every cycle the model timeline is live, the DUT must match it exactly.
  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t: got %h, want %h", $time, act, exp_v);
      end
    end
  end

  // Plans a request from the rules, drives it, and replays the expected timeline.
  task automatic run_req(input logic lane, input logic dir, input logic ld, input int steps,
                         input int oor_at, output int done_off, output logic st,
                         output int npul, output int dut_done, output logic dut_st,
                         output int dut_act, output int dut_other);
    logic [1:0][7:0] t;
    int              n;
    logic            stop;
    int              oor_from;
    t = m_tap; n = 0; st = 1'b0; stop = 1'b0; oor_from = -1;
    if (ld) begin
      done_off = 2 + S;
    end else if (steps == 0) begin
      done_off = 1;
    end else begin
      while (!stop) begin
        if (dir ? (t[lane] == TMAX8) : (t[lane] == 8'd0)) begin
          st = 1'b1; stop = 1'b1;
        end else begin
          n++;
          t[lane] = dir ? t[lane] + 8'd1 : t[lane] - 8'd1;
          if (oor_at == n) begin
            st = 1'b1; stop = 1'b1; oor_from = 3 + (1 + S) * (n - 1);
          end else if (n == steps) begin
            stop = 1'b1;
          end
        end
      end
      done_off = 2 + (1 + S) * n;
    end
    npul = n;
    for (int k = 0; k <= done_off + 1; k++) begin
      logic [1:0][7:0] tt;
      logic [1:0]      dd;
      int              c;
      logic            mv;
      tt = m_tap; dd = m_dir; c = 0; mv = 1'b0;
      for (int j = 0; j < npul; j++) begin
        if (2 + (1 + S) * j <= k) c++;
        if (2 + (1 + S) * j == k) mv = 1'b1;
      end
      if (ld) begin
        if (k >= 1) tt[lane] = TDEF8;
      end else if (dir) begin
        tt[lane] = tt[lane] + 8'(c);
      end else begin
        tt[lane] = tt[lane] - 8'(c);
      end
      if (!ld && steps != 0 && k >= 1) dd[lane] = dir;
      tl[k] = pack(k >= done_off, k == done_off, st && (k == done_off), lane && mv,
                   !lane && mv, lane && ld && (k == 1), !lane && ld && (k == 1), dd, tt);
    end
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_lane  = lane;
    bus.req_dir   = dir;
    bus.req_load  = ld;
    bus.req_steps = 8'(steps);
    dut_done = -1; dut_st = 1'b0; dut_act = 0; dut_other = 0;
    for (int k = 0; k <= done_off + 1; k++) begin
      @(posedge clk);
      #1;
      exp_v = tl[k];
      if (k == 0) begin
        bus.req_valid = 1'b0;
        bus.req_lane  = 1'($urandom_range(0, 1));
        bus.req_dir   = 1'($urandom_range(0, 1));
        bus.req_load  = 1'($urandom_range(0, 1));
        bus.req_steps = 8'($urandom_range(0, 255));
      end
      if (lane) begin
        oor1 = (oor_from >= 0) && (k >= oor_from) && (k < done_off);
        oor0 = 1'($urandom_range(0, 1));
      end else begin
        oor0 = (oor_from >= 0) && (k >= oor_from) && (k < done_off);
        oor1 = 1'($urandom_range(0, 1));
      end
      if (bus.done && dut_done < 0) begin
        dut_done = k;
        dut_st   = bus.status_oor;
      end
      if (lane ? (mv1 | ld1) : (mv0 | ld0)) dut_act++;
      if (lane ? (mv0 | ld0) : (mv1 | ld1)) dut_other++;
    end
    oor0 = 1'b0;
    oor1 = 1'b0;
    m_tap = tl[done_off + 1][15:0];
    m_dir = tl[done_off + 1][17:16];
  endtask

  function automatic logic [24:0] idle_vec();
    return pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_dir, m_tap);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int              d_off, d_np, d_dd, d_act, d_oth;
    logic            d_st, d_dst;
    logic [24:0]     rst_vec;
    logic [1:0][7:0] rst_taps;
    rst_taps = {TDEF8, TDEF8};
    rst_vec  = pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, rst_taps);
    bus.req_valid = 1'b0; bus.req_lane = 1'b0; bus.req_dir = 1'b0;
    bus.req_load  = 1'b0; bus.req_steps = 8'd0;
    oor0 = 1'b0; oor1 = 1'b0;
    m_tap = rst_taps; m_dir = 2'b00; exp_v = rst_vec;

    #1 arst = 1'b1;
    #11;
    chk("reset_state", 32'(act), 32'(rst_vec));
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    #1 chk("ready_low_before_edge", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1 chk("ready_after_release", 32'(bus.req_ready), 32'd1);
    exp_v  = idle_vec();
    chk_en = 1'b1;

    // Lane 0, +3 from tap 1.
    run_req(1'b0, 1'b1, 1'b0, 3, 0, d_off, d_st, d_np, d_dd, d_dst, d_act, d_oth);
    chk("s1_model_done_off", 32'(d_off), 32'd14);
    chk("s1_dut_done_off", 32'(d_dd), 32'd14);
    chk("s1_pulses", 32'(d_act), 32'd3);
    chk("s1_tap0", 32'(bus.tap_0), 32'd4);
    chk("s1_status", 32'(d_dst), 32'd0);
    chk("s1_lane1_quiet", 32'(d_oth), 32'd0);

    // Lane 1 up to 9, then load.
    run_req(1'b1, 1'b1, 1'b0, 8, 0, d_off, d_st, d_np, d_dd, d_dst, d_act, d_oth);
    chk("s2_tap1_moved", 32'(bus.tap_1), 32'd9);
    run_req(1'b1, 1'b0, 1'b1, 7, 0, d_off, d_st, d_np, d_dd, d_dst, d_act, d_oth);
    chk("s2_model_done_off", 32'(d_off), 32'd5);
    chk("s2_dut_done_off", 32'(d_dd), 32'd5);
    chk("s2_load_pulses", 32'(d_act), 32'd1);
    chk("s2_tap1", 32'(bus.tap_1), 32'd1);

    // Lane 0 back to 1, then -5 runs into 0.
    run_req(1'b0, 1'b0, 1'b1, 0, 0, d_off, d_st, d_np, d_dd, d_dst, d_act, d_oth);
    run_req(1'b0, 1'b0, 1'b0, 5, 0, d_off, d_st, d_np, d_dd, d_dst, d_act, d_oth);
    chk("s3_model_done_off", 32'(d_off), 32'd6);
    chk("s3_pulses", 32'(d_act), 32'd1);
    chk("s3_tap0", 32'(bus.tap_0), 32'd0);
    chk("s3_status", 32'(d_dst), 32'd1);

    // Lane 1, +10 with out-of-range after the second pulse.
    run_req(1'b1, 1'b1, 1'b0, 10, 2, d_off, d_st, d_np, d_dd, d_dst, d_act, d_oth);
    chk("s4_model_done_off", 32'(d_off), 32'd10);
    chk("s4_pulses", 32'(d_act), 32'd2);
    chk("s4_tap1", 32'(bus.tap_1), 32'd3);
    chk("s4_status", 32'(d_dst), 32'd1);

    // Zero steps.
    run_req(1'b0, 1'b1, 1'b0, 0, 0, d_off, d_st, d_np, d_dd, d_dst, d_act, d_oth);
    chk("s5_dut_done_off", 32'(d_dd), 32'd1);
    chk("s5_pulses", 32'(d_act), 32'd0);
    chk("s5_taps", 32'({bus.tap_1, bus.tap_0}), 32'({8'd3, 8'd0}));

    // Asynchronous reset in the gap after the first pulse.
    chk_en = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_lane = 1'b0; bus.req_dir = 1'b1;
    bus.req_load  = 1'b0; bus.req_steps = 8'd5;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("s6_first_pulse", 32'(mv0), 32'd1);
    @(posedge clk);
    #3 arst = 1'b1;
    #1 chk("s6_async_clear", 32'(act), 32'(rst_vec));
    @(posedge clk);
    #1 chk("s6_reset_hold", 32'(act), 32'(rst_vec));
    @(negedge clk);
    arst = 1'b0;
    #1 chk("s6_ready_low", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1 chk("s6_ready_after_release", 32'(bus.req_ready), 32'd1);
    m_tap  = rst_taps;
    m_dir  = 2'b00;
    exp_v  = idle_vec();
    chk_en = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      logic lane, dir, ld;
      int   steps, oor_at;
      lane  = 1'($urandom_range(0, 1));
      dir   = 1'($urandom_range(0, 1));
      ld    = ($urandom_range(0, 7) == 0);
      steps = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 15));
      oor_at = 0;
      if (!ld && steps > 0 && $urandom_range(0, 3) == 0) oor_at = int'($urandom_range(1, steps));
      run_req(lane, dir, ld, steps, oor_at, d_off, d_st, d_np, d_dd, d_dst, d_act, d_oth);
      chk("rnd_done_off", 32'(d_dd), 32'(d_off));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ddr4_ba_dly_step_ctrl.md
DDR4_BA_DLY_STEP_CTRL -- requirements
Module: ddr4_ba_dly_step_ctrl

Interface
REQ-001 Parameters SHALL be:
- SETTLE_CYCLES, 3, idle cycles after each delay-line pulse (1..15).
- TAP_DEFAULT, 1, tap value restored by a load.
- TAP_MAX, 255, highest legal tap count.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- FAB_CLK  in  1  fabric clock, the same clock that drives the IOD TX_CLK.
- ARST  in  1  reset, asynchronous, active-high.
- REQ_VALID  in  1  step request valid.
- REQ_READY  out  1  controller can accept a request.
- REQ_LANE  in  1  target lane (0 = BA0 IOD, 1 = BA1 IOD).
- REQ_DIR  in  1  1 = increment delay, 0 = decrement delay.
- REQ_LOAD  in  1  1 = load TAP_DEFAULT; REQ_DIR and REQ_STEPS are ignored.
- REQ_STEPS  in  8  number of taps to move.
- DONE  out  1  one-cycle completion pulse.
- STATUS_OOR  out  1  request ended out of range; valid while DONE=1.
- TAP_0, TAP_1  out  8 each  tracked tap count per lane.
- DELAY_LINE_MOVE_0/1, DELAY_LINE_DIRECTION_0/1, DELAY_LINE_LOAD_0/1  out  1 each  drive the IOD delay-line controls.
- DELAY_LINE_OUT_OF_RANGE_0/1  in  1 each  range flags from the IOD.

Function
REQ-003 REQ_READY SHALL be 1 only in state IDLE; a request is accepted on a cycle with REQ_VALID=1 and REQ_READY=1, and its fields are registered on that cycle.
REQ-004 FSM states SHALL be IDLE, SETUP, PULSE, LOAD, GAP and DONE.
REQ-005 On accept, the FSM SHALL go to LOAD if REQ_LOAD=1, to DONE if REQ_STEPS=0, and otherwise to SETUP.
REQ-006 SETUP SHALL last one cycle and drive the selected lane's DELAY_LINE_DIRECTION to REQ_DIR, so direction is set up at least one cycle before the first MOVE.
REQ-007 Before each pulse, the FSM SHALL check the tap boundary: an increment at TAP_MAX or a decrement at 0 goes to DONE with STATUS_OOR=1 and issues no pulse.
REQ-008 PULSE SHALL assert the selected lane's DELAY_LINE_MOVE for exactly one cycle, update that lane's TAP by +1 or -1 on the same edge, and decrement the remaining-step count.
REQ-009 LOAD SHALL assert the selected lane's DELAY_LINE_LOAD for exactly one cycle and set that lane's TAP to TAP_DEFAULT.
REQ-010 GAP SHALL last exactly SETTLE_CYCLES cycles; on its last cycle the selected lane's OUT_OF_RANGE input is sampled.
REQ-011 GAP exit rules SHALL be:
- OUT_OF_RANGE sampled as 1 -> DONE with STATUS_OOR=1.
- remaining steps > 0 -> PULSE; SETUP is not repeated and direction stays stable.
- otherwise -> DONE with STATUS_OOR=0.
REQ-012 DONE SHALL last one cycle with DONE=1 and then return to IDLE.
REQ-013 Latency SHALL be 2 + N*(1+SETTLE_CYCLES) cycles from the accept edge to the DONE cycle for an N-step move with no boundary or range hit, and 2+SETTLE_CYCLES cycles for a load.
REQ-014 The non-selected lane's controls SHALL stay at 0, except its DIRECTION, which holds its last value.
REQ-015 All DELAY_LINE_* outputs, DONE and STATUS_OOR SHALL be registered, with no combinational path from the inputs.

Reset
REQ-016 While ARST=1, and immediately on its assertion (including mid-operation), the block SHALL force:
- FSM to IDLE and REQ_READY=0;
- all MOVE, LOAD and DIRECTION outputs, DONE and STATUS_OOR to 0;
- TAP_0 and TAP_1 to TAP_DEFAULT.
REQ-017 REQ_READY SHALL rise on the first FAB_CLK edge after ARST deasserts.

Structure
REQ-018 The FSM state enum and the TAP_DEFAULT/TAP_MAX constants SHALL live in the shared package ddr4_phy_dly_pkg.
REQ-019 The per-lane tap tracker SHALL be a sub-module, ddr4_dly_tap_cnt (load, increment, decrement, saturating), instantiated once per lane.

Verification
REQ-020 The bench SHALL cover these directed scenarios (SETTLE_CYCLES=3 unless stated):
- Lane 0, increment, 3 steps from TAP=1 -> three one-cycle MOVE_0 pulses 4 cycles apart; TAP_0=4; DONE on cycle 14 after accept; STATUS_OOR=0; all lane-1 controls stay 0.
- Lane 1, load, after TAP_1 has been moved to 9 -> one LOAD_1 pulse; TAP_1=1; DONE 5 cycles after accept.
- Lane 0, decrement, 5 steps from TAP=1 -> one pulse; TAP_0=0; DONE with STATUS_OOR=1; no second pulse.
- Lane 1, increment, 10 steps, with OUT_OF_RANGE_1 forced to 1 after the 2nd pulse -> exactly 2 pulses; TAP_1=3; STATUS_OOR=1.
- REQ_STEPS=0 -> DONE 1 cycle after accept; no MOVE pulse; taps unchanged.
- ARST asserted during the GAP after the 1st pulse -> all outputs 0 asynchronously; TAPs=1; REQ_READY=1 one edge after release.
